sys_array_stream: RTL and testbench

//  Weight-stationary systolic matrix-vector engine, successor to sys_array_basic.

---
 rtl/sys_array_stream.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sys_array_stream.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_stream.sv
// rtl/sys_array_stream.sv - weight-stationary systolic matrix-vector engine with skew, de-skew and handshakes
//
// Purpose:
//   Holds a runtime-sized W x L weight matrix and computes y[i] = sum_j Wt[i][j] * x[j]
//   for a stream of input vectors. Inputs arrive unskewed on all lanes at once. They are
//   skewed internally, pass through an ARRAY_MAX_W x ARRAY_MAX_L PE grid, and are
//   de-skewed so that every column of a result appears on the same cycle.
//   Latency is fixed at ARRAY_MAX_L + ARRAY_MAX_W cycles. Throughput is one vector per cycle.
//   A load/run/drain controller keeps weight loads away from vectors that are in flight.
//
// Optional feature:
//   SYS_ARRAY_SATURATE_EN - when defined, each PE add saturates at 2^ACC_WIDTH-1.
//                           When undefined, sums wrap modulo 2^ACC_WIDTH.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high
//   weights_load   in   load request for weight_data and sizes
//   weights_ready  out  load accepted when high together with weights_load
//   array_w_w      in   active columns minus 1, latched on load
//   array_w_l      in   active input length minus 1, latched on load
//   weight_data    in   full weight matrix [i][j]
//   in_valid       in   input vector valid
//   in_ready       out  input vector accepted when in_valid && in_ready
//   in_data        in   unskewed input vector [j]
//   out_valid      out  result vector valid
//   out_ready      in   consumer accepts result
//   out_data       out  de-skewed result vector [i]
//   busy           out  vectors in flight

module sys_array_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int ARRAY_MAX_W = 10,
    parameter int ARRAY_MAX_L = 10,
    parameter int ACC_WIDTH   = 2 * DATA_WIDTH
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   weights_load,
    output logic                                                   weights_ready,
    input  logic [$clog2(ARRAY_MAX_W)-1:0]                         array_w_w,
    input  logic [$clog2(ARRAY_MAX_L)-1:0]                         array_w_l,
    input  logic [ARRAY_MAX_W-1:0][ARRAY_MAX_L-1:0][DATA_WIDTH-1:0] weight_data,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [ARRAY_MAX_L-1:0][DATA_WIDTH-1:0]                 in_data,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [ARRAY_MAX_W-1:0][ACC_WIDTH-1:0]                  out_data,
    output logic                                                   busy
);

    localparam int LAT = ARRAY_MAX_L + ARRAY_MAX_W;
    localparam int IFW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_READY,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IFW-1:0] r_inflight;
    logic [IFW-1:0] w_inflight_next;

    // Latched weights (rows beyond the active width are stored as zero) and lane enables.
    logic [DATA_WIDTH-1:0]  r_wt [ARRAY_MAX_W][ARRAY_MAX_L];
    logic [ARRAY_MAX_L-1:0] r_lane_en;

    // Valid bit travels alongside the data wavefront; the last stage is out_valid.
    logic [LAT:0] r_vp;

    logic w_stall;
    logic w_adv;
    logic w_accept;
    logic w_load_acc;
    logic w_out_hs;

    logic [DATA_WIDTH-1:0] w_skew_out [ARRAY_MAX_L];
    logic [DATA_WIDTH-1:0] w_x_out    [ARRAY_MAX_W][ARRAY_MAX_L];
    logic [ACC_WIDTH-1:0]  w_ps_out   [ARRAY_MAX_W][ARRAY_MAX_L];

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    assign out_valid     = r_vp[LAT];
    assign w_stall       = out_valid && !out_ready;
    assign w_adv         = !w_stall;
    assign weights_ready = (r_inflight == '0);
    assign busy          = (r_inflight != '0);
    // A pending load blocks new inputs, so a busy array drains and the load then goes in.
    assign in_ready      = (r_state != ST_EMPTY) && !w_stall && !weights_load;
    assign w_accept      = in_valid && in_ready;
    assign w_load_acc    = weights_load && weights_ready;
    assign w_out_hs      = out_valid && out_ready;

    always_comb begin
        w_inflight_next = r_inflight;
        if (w_accept && !w_out_hs) begin
            w_inflight_next = r_inflight + IFW'(1);
        end else if (!w_accept && w_out_hs) begin
            w_inflight_next = r_inflight - IFW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_load_acc) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_inflight_next == '0) begin
                    w_state_next = ST_READY;
                end else if (!in_valid) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_inflight_next == '0) begin
                    w_state_next = ST_READY;
                end else if (w_accept) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_inflight <= '0;
            r_vp       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_inflight_next;
            if (w_adv) begin
                r_vp <= {r_vp[LAT-1:0], w_accept};
            end
        end
    end

    // ------------------------------------------------------------------
    // Weight and size latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_en <= '0;
            for (int i = 0; i < ARRAY_MAX_W; i++) begin
                for (int j = 0; j < ARRAY_MAX_L; j++) begin
                    r_wt[i][j] <= '0;
                end
            end
        end else if (w_load_acc) begin
            for (int j = 0; j < ARRAY_MAX_L; j++) begin
                r_lane_en[j] <= (32'(array_w_l) >= j);
            end
            // Zeroed rows make inactive columns produce 0 without an output mask.
            for (int i = 0; i < ARRAY_MAX_W; i++) begin
                for (int j = 0; j < ARRAY_MAX_L; j++) begin
                    r_wt[i][j] <= (32'(array_w_w) >= i) ? weight_data[i][j] : '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Input skew: lane j passes through j+1 registers. Idle cycles inject zero,
    // so bubbles produce zero partial sums.
    // ------------------------------------------------------------------
    for (genvar gj = 0; gj < ARRAY_MAX_L; gj++) begin : g_skew
        logic [DATA_WIDTH-1:0] r_skw [gj+1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= gj; k++) begin
                    r_skw[k] <= '0;
                end
            end else if (w_adv) begin
                r_skw[0] <= (w_accept && r_lane_en[gj]) ? in_data[gj] : '0;
                for (int k = 1; k <= gj; k++) begin
                    r_skw[k] <= r_skw[k-1];
                end
            end
        end

        assign w_skew_out[gj] = r_skw[gj];
    end

    // ------------------------------------------------------------------
    // PE grid: x[j] flows down the rows. The partial sum for column i flows across j.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < ARRAY_MAX_W; gi++) begin : g_row
        for (genvar gj = 0; gj < ARRAY_MAX_L; gj++) begin : g_col
            logic [DATA_WIDTH-1:0] w_x_in;
            logic [ACC_WIDTH-1:0]  w_ps_in;
            logic [ACC_WIDTH-1:0]  w_prod;
            logic [ACC_WIDTH-1:0]  w_sum;
            logic [DATA_WIDTH-1:0] r_x;
            logic [ACC_WIDTH-1:0]  r_ps;

            if (gi == 0) begin : g_x_top
                assign w_x_in = w_skew_out[gj];
            end else begin : g_x_mid
                assign w_x_in = w_x_out[gi-1][gj];
            end

            if (gj == 0) begin : g_ps_first
                assign w_ps_in = '0;
            end else begin : g_ps_next
                assign w_ps_in = w_ps_out[gi][gj-1];
            end

            assign w_prod = ACC_WIDTH'({{DATA_WIDTH{1'b0}}, r_wt[gi][gj]} *
                                       {{DATA_WIDTH{1'b0}}, w_x_in});

`ifdef SYS_ARRAY_SATURATE_EN
            // A carry out clamps to all ones. A clamped sum stays clamped because later adds are non-negative.
            logic [ACC_WIDTH:0] w_sum_ext;
            assign w_sum_ext = {1'b0, w_ps_in} + {1'b0, w_prod};
            assign w_sum     = w_sum_ext[ACC_WIDTH] ? '1 : w_sum_ext[ACC_WIDTH-1:0];
`else
            assign w_sum = w_ps_in + w_prod;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_x  <= '0;
                    r_ps <= '0;
                end else if (w_adv) begin
                    r_x  <= w_x_in;
                    r_ps <= w_sum;
                end
            end

            assign w_x_out[gi][gj]  = r_x;
            assign w_ps_out[gi][gj] = r_ps;
        end
    end

    // ------------------------------------------------------------------
    // Output de-skew: column i finishes i cycles after column 0, so it takes
    // ARRAY_MAX_W-i stages here (the last stage is the output register).
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < ARRAY_MAX_W; gi++) begin : g_deskew
        localparam int D = ARRAY_MAX_W - gi;
        logic [ACC_WIDTH-1:0] r_dsk [D];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < D; k++) begin
                    r_dsk[k] <= '0;
                end
            end else if (w_adv) begin
                r_dsk[0] <= w_ps_out[gi][ARRAY_MAX_L-1];
                for (int k = 1; k < D; k++) begin
                    r_dsk[k] <= r_dsk[k-1];
                end
            end
        end

        assign out_data[gi] = r_dsk[D-1];
    end

endmodule

// File: tb/tb_sys_array_stream.sv
// tb/tb_sys_array_stream.sv - directed self-checking bench for sys_array_stream

module tb_sys_array_stream;

    localparam int DW  = 8;
    localparam int MW  = 10;
    localparam int ML  = 10;
    localparam int AW  = 16;
    localparam int LAT = MW + ML;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic weights_load = 1'b0;
    logic weights_ready;
    logic [3:0] array_w_w = 4'd0;
    logic [3:0] array_w_l = 4'd0;
    logic [MW-1:0][ML-1:0][DW-1:0] weight_data = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [ML-1:0][DW-1:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [MW-1:0][AW-1:0] out_data;
    logic busy;

    logic [MW-1:0][AW-1:0] exp_v;
    int checks = 0;
    int errors = 0;

    sys_array_stream #(
        .DATA_WIDTH (DW),
        .ARRAY_MAX_W(MW),
        .ARRAY_MAX_L(ML),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .weights_load (weights_load),
        .weights_ready(weights_ready),
        .array_w_w    (array_w_w),
        .array_w_l    (array_w_l),
        .weight_data  (weight_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: Wt[i][j]=2i+j+1 for i<5,j<2, filler 7 elsewhere; mode 1: all 255; mode 2: all 1
    task automatic set_weights(input int mode);
        for (int i = 0; i < MW; i++) begin
            for (int j = 0; j < ML; j++) begin
                if (mode == 0) weight_data[i][j] = (i < 5 && j < 2) ? DW'(2*i + j + 1) : 8'd7;
                else if (mode == 1) weight_data[i][j] = 8'd255;
                else weight_data[i][j] = 8'd1;
            end
        end
    endtask

    // Lanes 0..2 get a,b,c; the rest get filler 9, which must be masked off.
    task automatic set_x(input int a, input int b, input int c);
        for (int j = 0; j < ML; j++) in_data[j] = 8'd9;
        in_data[0] = DW'(a);
        in_data[1] = DW'(b);
        in_data[2] = DW'(c);
    endtask

    function automatic logic [MW-1:0][AW-1:0] pack5(input int a, input int b, input int c,
                                                     input int d, input int e);
        logic [MW-1:0][AW-1:0] v;
        v = '0;
        v[0] = AW'(a); v[1] = AW'(b); v[2] = AW'(c); v[3] = AW'(d); v[4] = AW'(e);
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checks++; if (weights_ready !== 1'b1) begin errors++; $display("FAIL reset_weights_ready: got %b want 1", weights_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        set_weights(0);
        array_w_w = 4'd4;
        array_w_l = 4'd1;
        weights_load = 1'b1;
        #1;
        checks++; if (weights_ready !== 1'b1) begin errors++; $display("FAIL basic_load_ready: got %b want 1", weights_ready); end
        tick();
        weights_load = 1'b0;
        in_valid = 1'b1;
        set_x(1, 2, 0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        tick();
        set_x(3, 4, 0);
        tick();
        in_valid = 1'b0;
        repeat (LAT - 2) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        tick();
        exp_v = pack5(5, 11, 17, 23, 29);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_at_lat: got %b want 1", out_valid); end
        checks++; if (out_data !== exp_v) begin errors++; $display("FAIL basic_vec1: got %h want %h", out_data, exp_v); end
        tick();
        exp_v = pack5(11, 25, 39, 53, 67);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid2: got %b want 1", out_valid); end
        checks++; if (out_data !== exp_v) begin errors++; $display("FAIL basic_vec2: got %h want %h", out_data, exp_v); end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_x(1, 2, 0);
        tick();
        set_x(3, 4, 0);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 2 * LAT) begin tick(); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: got out_valid=%b want 1", out_valid); end
        exp_v = pack5(5, 11, 17, 23, 29);
        checks++; if (out_data !== exp_v) begin errors++; $display("FAIL bp_first: got %h want %h", out_data, exp_v); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exp_v) begin errors++; $display("FAIL bp_hold%0d: got v=%b %h want 1 %h", k, out_valid, out_data, exp_v); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        exp_v = pack5(11, 25, 39, 53, 67);
        checks++; if (out_valid !== 1'b1 || out_data !== exp_v) begin errors++; $display("FAIL bp_second: got v=%b %h want 1 %h", out_valid, out_data, exp_v); end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_load_busy();
        int n;
        in_valid = 1'b1;
        set_x(1, 2, 0);
        tick();
        in_valid = 1'b0;
        set_weights(2);
        array_w_w = 4'd2;
        array_w_l = 4'd2;
        weights_load = 1'b1;
        #1;
        checks++; if (weights_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lb_held: got ready=%b busy=%b want 0 1", weights_ready, busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lb_in_ready: got %b want 0", in_ready); end
        n = 0;
        while (!out_valid && n < 2 * LAT) begin tick(); n++; end
        exp_v = pack5(5, 11, 17, 23, 29);
        checks++; if (out_valid !== 1'b1 || out_data !== exp_v) begin errors++; $display("FAIL lb_old_weights: got v=%b %h want 1 %h", out_valid, out_data, exp_v); end
        checks++; if (weights_ready !== 1'b0) begin errors++; $display("FAIL lb_ready_at_out: got %b want 0", weights_ready); end
        tick();
        checks++; if (weights_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL lb_ready_after: got ready=%b valid=%b want 1 0", weights_ready, out_valid); end
        tick();
        weights_load = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lb_ready_state: got %b want 1", in_ready); end
        in_valid = 1'b1;
        set_x(1, 2, 3);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 2 * LAT) begin tick(); n++; end
        exp_v = pack5(6, 6, 6, 0, 0);
        checks++; if (out_valid !== 1'b1 || out_data !== exp_v) begin errors++; $display("FAIL lb_new_weights: got v=%b %h want 1 %h", out_valid, out_data, exp_v); end
        tick();
    endtask

    task automatic test_load_tie();
        set_weights(0);
        array_w_w = 4'd4;
        array_w_l = 4'd1;
        weights_load = 1'b1;
        in_valid = 1'b1;
        set_x(1, 2, 3);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL tie_in_ready: got %b want 0", in_ready); end
        checks++; if (weights_ready !== 1'b1) begin errors++; $display("FAIL tie_weights_ready: got %b want 1", weights_ready); end
        tick();
        weights_load = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tie_next_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tie_early_valid: got %b want 0", out_valid); end
        tick();
        exp_v = pack5(5, 11, 17, 23, 29);
        checks++; if (out_valid !== 1'b1 || out_data !== exp_v) begin errors++; $display("FAIL tie_result: got v=%b %h want 1 %h", out_valid, out_data, exp_v); end
        tick();
    endtask

    task automatic test_full_and_reset();
        int  nvalid;
        int  nlate;
        bit  first;
        logic [AW-1:0] exp_col;
`ifdef SYS_ARRAY_SATURATE_EN
        exp_col = 16'd65535;
`else
        exp_col = 16'd60426;
`endif
        for (int i = 0; i < MW; i++) exp_v[i] = exp_col;
        set_weights(1);
        array_w_w = 4'd9;
        array_w_l = 4'd9;
        weights_load = 1'b1;
        tick();
        weights_load = 1'b0;
        for (int j = 0; j < ML; j++) in_data[j] = 8'd255;
        in_valid = 1'b1;
        nvalid = 0;
        first = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid) begin
                nvalid++;
                if (first) begin
                    first = 1'b0;
                    checks++; if (out_data !== exp_v) begin errors++; $display("FAIL full_value: got %h want %h", out_data, exp_v); end
                end
            end
        end
        checks++; if (nvalid != 5) begin errors++; $display("FAIL full_count: got %0d want 5", nvalid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || weights_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl: got in_ready=%b weights_ready=%b want 0 1", in_ready, weights_ready); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rst_mid_out: got v=%b busy=%b %h want 0 0 0", out_valid, busy, out_data); end
        nlate = 0;
        repeat (LAT + 5) begin
            tick();
            if (out_valid) nlate++;
        end
        checks++; if (nlate != 0) begin errors++; $display("FAIL rst_mid_no_output: got %0d valid cycles want 0", nlate); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_load_busy();
        test_load_tie();
        test_full_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
